// File: rtl/main_memory_burst_if.sv
// Request/beat bus between the cache controller (master) and the burst memory (slave).
interface main_memory_burst_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(BURST_LEN);

  logic                  req_valid;
  logic                  req_ready;
  logic                  read_write_mem;
  logic                  burst_mem;
  logic [ADDR_WIDTH-1:0] address_mem;
  logic [DATA_WIDTH-1:0] write_data_mem;
  logic [BYTES-1:0]      byte_en_mem;
  logic                  wr_beat;
  logic [DATA_WIDTH-1:0] read_data_mem;
  logic                  rd_valid;
  logic [IDX_W-1:0]      beat_idx;
  logic                  Done;

  modport master (
    output req_valid, read_write_mem, burst_mem, address_mem, write_data_mem, byte_en_mem,
    input  req_ready, wr_beat, read_data_mem, rd_valid, beat_idx, Done
  );

  modport slave (
    input  req_valid, read_write_mem, burst_mem, address_mem, write_data_mem, byte_en_mem,
    output req_ready, wr_beat, read_data_mem, rd_valid, beat_idx, Done
  );
endinterface

// File: rtl/main_memory_burst.sv
// Byte-addressable memory with fixed access latency, single-beat and critical-word-first
// wrapping burst transfers, per-byte write enables and an end-of-transaction Done pulse.
module main_memory_burst #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned LATENCY    = 2
) (
  input logic                clk,
  input logic                rst,
  main_memory_burst_if.slave bus
);
  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(BURST_LEN);
  localparam int unsigned OFF_W      = $clog2(BYTES);
  localparam int unsigned LINE_BYTES = BURST_LEN * BYTES;
  localparam int unsigned CNT_W      = $clog2(LATENCY + 1);
  localparam int unsigned MEM_BYTES  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [IDX_W-1:0]      r_k, w_k_d, w_k_nxt, w_idx_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_cur_addr, w_nxt_addr;
  logic                  r_we, r_burst;
  logic [DATA_WIDTH-1:0] r_rdata, w_rd_word;
  logic                  r_rd_valid;
  logic [IDX_W-1:0]      r_beat_idx;
  logic                  w_last, w_enter_beat, w_wr_beat;
  logic [7:0]            r_mem [MEM_BYTES] = '{default: 8'h00};

  function automatic logic [IDX_W-1:0] f_word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  // Burst beats wrap inside the line; a single beat keeps its byte alignment.
  function automatic logic [ADDR_WIDTH-1:0] f_beat_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic burst,
                                                        input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] idx;
    idx = f_word_idx(a) + k;
    if (!burst) return a;
    return (a & ~ADDR_WIDTH'(LINE_BYTES - 1)) | (ADDR_WIDTH'(idx) << OFF_W);
  endfunction

  assign w_last       = !r_burst || (r_k == IDX_W'(BURST_LEN - 1));
  assign w_enter_beat = ((r_state == StWait) && (r_cnt == CNT_W'(1))) ||
                        ((r_state == StXfer) && !w_last);
  assign w_k_nxt      = (r_state == StXfer) ? r_k + IDX_W'(1) : '0;
  assign w_idx_nxt    = f_word_idx(r_addr) + w_k_nxt;
  assign w_cur_addr   = f_beat_addr(r_addr, r_burst, r_k);
  assign w_nxt_addr   = f_beat_addr(r_addr, r_burst, w_k_nxt);
  assign w_wr_beat    = (r_state == StXfer) && r_we;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_k_d     = r_k;
    case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          w_state_d = StWait;
          w_cnt_d   = CNT_W'(LATENCY);
        end
      end
      StWait: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_d = StXfer;
          w_k_d     = '0;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StXfer: begin
        if (w_last) w_state_d = StDone;
        else        w_k_d     = r_k + IDX_W'(1);
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Read beat is fetched one edge early so the registered outputs line up with the beat cycle.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_rd_word[8*i +: 8] = r_mem[w_nxt_addr + ADDR_WIDTH'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_k        <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_burst    <= 1'b0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_beat_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_k        <= w_k_d;
      r_rd_valid <= w_enter_beat && !r_we;
      if ((r_state == StIdle) && bus.req_valid) begin
        r_addr  <= bus.address_mem;
        r_we    <= bus.read_write_mem;
        r_burst <= bus.burst_mem;
      end
      if (w_enter_beat) begin
        r_beat_idx <= w_idx_nxt;
        if (!r_we) r_rdata <= w_rd_word;
      end
    end
  end

  // Storage is deliberately outside reset: an aborted burst keeps the beats already written.
  always_ff @(posedge clk) begin
    if (w_wr_beat) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.byte_en_mem[i]) r_mem[w_cur_addr + ADDR_WIDTH'(i)] <= bus.write_data_mem[8*i +: 8];
      end
    end
  end

  assign bus.req_ready     = (r_state == StIdle);
  assign bus.Done          = (r_state == StDone);
  assign bus.wr_beat       = w_wr_beat;
  assign bus.read_data_mem = r_rdata;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.beat_idx      = r_beat_idx;
endmodule

// File: tb/tb_main_memory_burst.sv
// Directed plus random transactions against a byte-array reference of the burst memory.
module tb_main_memory_burst;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_memory_burst_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BURST_LEN(4)) bus ();

  main_memory_burst #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .BURST_LEN (4),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  ref_mem [1024];
  logic [31:0] wd  [4];
  logic [3:0]  be  [4];
  logic [31:0] obs [4];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Byte address touched by byte i of beat k.
  function automatic logic [9:0] m_addr(input logic [9:0] a, input bit burst, input int k,
                                        input int i);
    int ai, line, w0;
    ai = int'(a);
    if (!burst) return 10'((ai + i) % 1024);
    line = ai - (ai % 16);
    w0   = (ai / 4) % 4;
    return 10'(line + ((w0 + k) % 4) * 4 + i);
  endfunction

  function automatic logic [31:0] m_word(input logic [9:0] a, input bit burst, input int k);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[m_addr(a, burst, k, i)];
    return w;
  endfunction

  // Runs one transaction from an idle negedge; abort_c>0 asserts rst for 2 edges from that cycle.
  task automatic run_txn(input bit we, input bit burst, input logic [9:0] a, input int abort_c,
                         input bit hold);
    int n;
    n = burst ? 4 : 1;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid      = 1'b1;
    bus.read_write_mem = we;
    bus.burst_mem      = burst;
    bus.address_mem    = a;
    bus.write_data_mem = $urandom;
    bus.byte_en_mem    = '0;
    @(posedge clk);
    for (int c = 1; c <= LAT + n + 1; c++) begin
      bit beat;
      int k;
      @(negedge clk);
      bus.req_valid = hold;
      beat = (c > LAT) && (c <= LAT + n);
      k    = c - LAT - 1;
      chk("busy_ready", 32'(bus.req_ready), 32'd0);
      chk("done", 32'(bus.Done), 32'(c == LAT + n + 1));
      chk("rd_valid", 32'(bus.rd_valid), 32'(beat && !we));
      chk("wr_beat", 32'(bus.wr_beat), 32'(beat && we));
      if (beat) chk("beat_idx", 32'(bus.beat_idx), 32'((((int'(a) / 4) % 4) + k) % 4));
      if (beat && !we) begin
        obs[k] = bus.read_data_mem;
        chk("rdata", bus.read_data_mem, m_word(a, burst, k));
      end
      if (beat && we) begin
        bus.write_data_mem = wd[k];
        bus.byte_en_mem    = be[k];
        for (int i = 0; i < 4; i++)
          if (be[k][i]) ref_mem[m_addr(a, burst, k, i)] = wd[k][8*i +: 8];
      end
      if (c == abort_c) begin
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_done", 32'(bus.Done), 32'd0);
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        return;
      end
    end
    @(negedge clk);
    chk("end_ready", 32'(bus.req_ready), 32'd1);
    chk("end_done", 32'(bus.Done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    bus.req_valid      = 1'b0;
    bus.read_write_mem = 1'b0;
    bus.burst_mem      = 1'b0;
    bus.address_mem    = '0;
    bus.write_data_mem = '0;
    bus.byte_en_mem    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wr_beat", 32'(bus.wr_beat), 32'd0);
    chk("rst_rdata", bus.read_data_mem, 32'd0);
    chk("rst_beat_idx", 32'(bus.beat_idx), 32'd0);

    // Reset in the middle of a burst read, then a clean read of 0x000.
    run_txn(1'b0, 1'b1, 10'h100, 4, 1'b0);
    run_txn(1'b0, 1'b0, 10'h000, 0, 1'b0);
    chk("rst_then_read0", obs[0], 32'h0000_0000);

    // Single write/read.
    wd[0] = 32'hDEAD_BEEF; be[0] = 4'hF;
    run_txn(1'b1, 1'b0, 10'h020, 0, 1'b0);
    run_txn(1'b0, 1'b0, 10'h020, 0, 1'b0);
    chk("single_rw", obs[0], 32'hDEAD_BEEF);

    // Burst write, then critical-word-first wrapped read.
    wd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    be = '{4'hF, 4'hF, 4'hF, 4'hF};
    run_txn(1'b1, 1'b1, 10'h010, 0, 1'b0);
    run_txn(1'b0, 1'b1, 10'h01B, 0, 1'b0);
    chk("wrap_b0", obs[0], 32'h3333_3333);
    chk("wrap_b1", obs[1], 32'h4444_4444);
    chk("wrap_b2", obs[2], 32'h1111_1111);
    chk("wrap_b3", obs[3], 32'h2222_2222);

    // Byte enables.
    wd[0] = 32'hFFFF_FFFF; be[0] = 4'b0101;
    run_txn(1'b1, 1'b0, 10'h040, 0, 1'b0);
    run_txn(1'b0, 1'b0, 10'h040, 0, 1'b0);
    chk("byte_en", obs[0], 32'h00FF_00FF);

    // Single write across the top of the address space.
    wd[0] = 32'hAABB_CCDD; be[0] = 4'hF;
    run_txn(1'b1, 1'b0, 10'h3FE, 0, 1'b0);
    run_txn(1'b0, 1'b0, 10'h000, 0, 1'b0);
    chk("addr_wrap", obs[0], 32'h0000_AABB);

    // req_valid held high: one acceptance per transaction, the next one in cycle 8.
    run_txn(1'b0, 1'b1, 10'h010, 0, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("hold_reaccept", 32'(bus.req_ready), 32'd0);
    repeat (7) @(negedge clk);
    chk("hold_drained", 32'(bus.req_ready), 32'd1);

    // Reset during beat 1 of a burst write.
    wd = '{32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3};
    be = '{4'hF, 4'hF, 4'hF, 4'hF};
    run_txn(1'b1, 1'b1, 10'h080, 4, 1'b0);
    run_txn(1'b0, 1'b1, 10'h080, 0, 1'b0);
    chk("abort_b0", obs[0], 32'hA0A0_A0A0);
    chk("abort_b1", obs[1], 32'hA1A1_A1A1);
    chk("abort_b2", obs[2], 32'h0000_0000);
    chk("abort_b3", obs[3], 32'h0000_0000);

    // Random traffic against the reference array.
    repeat (60) begin
      bit          we, burst;
      logic [9:0]  a;
      we    = 1'($urandom);
      burst = 1'($urandom);
      a     = 10'($urandom);
      for (int j = 0; j < 4; j++) begin
        wd[j] = $urandom;
        be[j] = 4'($urandom);
      end
      run_txn(we, burst, a, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
